// File: rtl/delay_line_pkg.sv
// Shared types and helpers for the multi-channel circular delay line.
package delay_line_pkg;

    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_MEM_DEPTH  = 1024;
    localparam int DEF_NUM_CH     = 2;
    localparam int DEF_ADDR_WIDTH = $clog2(DEF_MEM_DEPTH);
    localparam int DEF_CH_WIDTH   = (DEF_NUM_CH > 1) ? $clog2(DEF_NUM_CH) : 1;
    localparam int TOTAL_DEPTH    = DEF_NUM_CH * DEF_MEM_DEPTH;

    typedef logic [DEF_CH_WIDTH-1:0]   ch_idx_t;
    typedef logic [DEF_ADDR_WIDTH-1:0] ptr_t;

    // Where the registered output sample comes from.
    typedef enum logic [1:0] {
        SRC_ZERO,
        SRC_PASS,
        SRC_MEM
    } src_t;

    function automatic int unsigned total_depth(
        input int unsigned ch,
        input int unsigned depth
    );
        return ch * depth;
    endfunction

    // Channel index sits above the per-channel pointer bits.
    function automatic int unsigned mk_addr(
        input int unsigned ch,
        input int unsigned ptr,
        input int unsigned aw
    );
        return (ch << aw) | ptr;
    endfunction

endpackage

// File: rtl/delay_line_mem.sv
// Simple dual-port sample store: one write port, one synchronous
// read-before-write read port, no reset so it maps onto block RAM.
module delay_line_mem #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 2048,
    parameter int ADDR_WIDTH = 11
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/delay_line_ram.sv
// Multi-channel circular delay line over one shared memory.
// Optional fill gating: define DELAY_LINE_FILL_GATE_EN.
module delay_line_ram
    import delay_line_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int MEM_DEPTH  = 1024,
    parameter int NUM_CH     = 2,
    parameter int ADDR_WIDTH = $clog2(MEM_DEPTH),
    parameter int CH_WIDTH   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                  pi_clk,
    input  logic                  pi_arst_n,
    input  logic                  pi_clear,
    input  logic                  pi_valid,
    output logic                  po_ready,
    input  logic [CH_WIDTH-1:0]   pi_ch,
    input  logic [DATA_WIDTH-1:0] pi_data,
    input  logic [ADDR_WIDTH-1:0] pi_delay,
    output logic                  po_valid,
    input  logic                  pi_ready,
    output logic [CH_WIDTH-1:0]   po_ch,
    output logic [DATA_WIDTH-1:0] po_data
);

    localparam int MAW   = CH_WIDTH + ADDR_WIDTH;
    localparam int DEPTH = total_depth(NUM_CH, MEM_DEPTH);
    localparam logic [CH_WIDTH:0] CH_LIM = (CH_WIDTH+1)'(NUM_CH);

    logic                  accept;
    logic                  ch_ok;
    logic                  gated;
    logic [ADDR_WIDTH-1:0] wr_ptr [NUM_CH];
    logic [ADDR_WIDTH-1:0] cur_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [MAW-1:0]        waddr;
    logic [MAW-1:0]        raddr;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic [DATA_WIDTH-1:0] pass_q;
    src_t                  src_d;
    src_t                  src_q;

    assign po_ready = !pi_clear && (!po_valid || pi_ready);
    assign accept   = pi_valid && po_ready;
    assign ch_ok    = {1'b0, pi_ch} < CH_LIM;
    assign cur_ptr  = ch_ok ? wr_ptr[pi_ch] : '0;
    assign rd_ptr   = cur_ptr - pi_delay;
    assign waddr    = MAW'(mk_addr(32'(pi_ch), 32'(cur_ptr), ADDR_WIDTH));
    assign raddr    = MAW'(mk_addr(32'(pi_ch), 32'(rd_ptr), ADDR_WIDTH));

`ifdef DELAY_LINE_FILL_GATE_EN
    logic [ADDR_WIDTH-1:0] fill [NUM_CH];
    logic [ADDR_WIDTH-1:0] cur_fill;

    assign cur_fill = ch_ok ? fill[pi_ch] : '0;
    assign gated    = pi_delay > cur_fill;

    // Saturates at MEM_DEPTH-1, the largest usable delay.
    always_ff @(posedge pi_clk or negedge pi_arst_n) begin
        if (!pi_arst_n) begin
            for (int i = 0; i < NUM_CH; i++) fill[i] <= '0;
        end else if (pi_clear) begin
            for (int i = 0; i < NUM_CH; i++) fill[i] <= '0;
        end else if (accept && ch_ok && cur_fill != '1) begin
            fill[pi_ch] <= cur_fill + ADDR_WIDTH'(1);
        end
    end
`else
    assign gated = 1'b0;
`endif

    always_ff @(posedge pi_clk or negedge pi_arst_n) begin
        if (!pi_arst_n) begin
            for (int i = 0; i < NUM_CH; i++) wr_ptr[i] <= '0;
        end else if (pi_clear) begin
            for (int i = 0; i < NUM_CH; i++) wr_ptr[i] <= '0;
        end else if (accept && ch_ok) begin
            wr_ptr[pi_ch] <= cur_ptr + ADDR_WIDTH'(1);
        end
    end

    always_comb begin
        src_d = SRC_MEM;
        if (!ch_ok) begin
            src_d = SRC_ZERO;
        end else if (pi_delay == '0) begin
            src_d = SRC_PASS;
        end else if (gated) begin
            src_d = SRC_ZERO;
        end
    end

    delay_line_mem #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (DEPTH),
        .ADDR_WIDTH(MAW)
    ) u_mem (
        .clk  (pi_clk),
        .we   (accept && ch_ok),
        .waddr(waddr),
        .wdata(pi_data),
        .re   (accept && ch_ok),
        .raddr(raddr),
        .rdata(mem_rdata)
    );

    // Memory read data only changes on accept, so it holds while stalled.
    always_ff @(posedge pi_clk or negedge pi_arst_n) begin
        if (!pi_arst_n) begin
            po_valid <= 1'b0;
            po_ch    <= '0;
            src_q    <= SRC_ZERO;
            pass_q   <= '0;
        end else if (accept) begin
            po_valid <= 1'b1;
            po_ch    <= pi_ch;
            src_q    <= src_d;
            pass_q   <= pi_data;
        end else if (pi_ready) begin
            po_valid <= 1'b0;
        end
    end

    always_comb begin
        po_data = '0;
        case (src_q)
            SRC_PASS: po_data = pass_q;
            SRC_MEM:  po_data = mem_rdata;
            default:  po_data = '0;
        endcase
    end

endmodule

// File: tb/tb_delay_line_ram.sv
// Randomised bench for delay_line_ram against a per-channel ring model.
module tb_delay_line_ram;

    localparam int DW = 16;
    localparam int MD = 8;
    localparam int NC = 2;
    localparam int AW = 3;
    localparam int CW = 1;

    logic          pi_clk = 1'b0;
    logic          pi_arst_n = 1'b0;
    logic          pi_clear = 1'b0;
    logic          pi_valid = 1'b0;
    logic          po_ready;
    logic [CW-1:0] pi_ch = '0;
    logic [DW-1:0] pi_data = '0;
    logic [AW-1:0] pi_delay = '0;
    logic          po_valid;
    logic          pi_ready = 1'b1;
    logic [CW-1:0] po_ch;
    logic [DW-1:0] po_data;

    delay_line_ram #(
        .DATA_WIDTH(DW),
        .MEM_DEPTH (MD),
        .NUM_CH    (NC)
    ) dut (
        .pi_clk   (pi_clk),
        .pi_arst_n(pi_arst_n),
        .pi_clear (pi_clear),
        .pi_valid (pi_valid),
        .po_ready (po_ready),
        .pi_ch    (pi_ch),
        .pi_data  (pi_data),
        .pi_delay (pi_delay),
        .po_valid (po_valid),
        .pi_ready (pi_ready),
        .po_ch    (po_ch),
        .po_data  (po_data)
    );

    always #5 pi_clk = ~pi_clk;

    int total = 0;
    int bad = 0;

    bit            e_valid;
    int            e_ch;
    logic [DW-1:0] e_data;
    bit            e_known;
    int            wp [NC];
    int            fl [NC];
    logic [DW-1:0] mm [NC][MD];
    bit            kn [NC][MD];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        e_valid = 1'b0;
        e_ch    = 0;
        e_data  = '0;
        e_known = 1'b1;
        for (int k = 0; k < NC; k++) begin
            wp[k] = 0;
            fl[k] = 0;
        end
    endtask

    task automatic cyc(input bit v, input int c, input int d,
                       input int dl, input bit clr, input bit rdy);
        bit er;
        bit acc;
        int ra;
        pi_valid = v;
        pi_ch    = c[0:0];
        pi_data  = d[15:0];
        pi_delay = dl[2:0];
        pi_clear = clr;
        pi_ready = rdy;
        #1;
        er = !clr && (!e_valid || rdy);
        chk("po_ready", 32'(po_ready), 32'(er));
        acc = v && er;
        if (acc) begin
            e_valid = 1'b1;
            e_ch    = c;
            if (dl == 0) begin
                e_data  = d[15:0];
                e_known = 1'b1;
            end
`ifdef DELAY_LINE_FILL_GATE_EN
            else if (dl > fl[c]) begin
                e_data  = '0;
                e_known = 1'b1;
            end
`endif
            else begin
                ra      = (wp[c] - dl + MD) % MD;
                e_data  = mm[c][ra];
                e_known = kn[c][ra];
            end
            mm[c][wp[c]] = d[15:0];
            kn[c][wp[c]] = 1'b1;
            wp[c] = (wp[c] + 1) % MD;
            if (fl[c] < MD - 1) fl[c]++;
        end else if (rdy) begin
            e_valid = 1'b0;
        end
        if (clr) begin
            for (int k = 0; k < NC; k++) begin
                wp[k] = 0;
                fl[k] = 0;
            end
        end
        @(negedge pi_clk);
        chk("po_valid", 32'(po_valid), 32'(e_valid));
        if (e_valid) begin
            chk("po_ch", 32'(po_ch), 32'(e_ch));
            if (e_known) chk("po_data", 32'(po_data), 32'(e_data));
        end
    endtask

    initial begin
        for (int c = 0; c < NC; c++)
            for (int a = 0; a < MD; a++) kn[c][a] = 1'b0;
        model_reset();
        repeat (3) @(negedge pi_clk);
        chk("rst_valid", 32'(po_valid), 32'd0);
        chk("rst_data", 32'(po_data), 32'd0);
        chk("rst_ch", 32'(po_ch), 32'd0);
        chk("rst_ready", 32'(po_ready), 32'd1);
        pi_arst_n = 1'b1;

        for (int i = 1; i <= 10; i++) cyc(1, 0, i, 3, 0, 1);
        cyc(1, 1, 'h1234, 0, 0, 1);
        for (int i = 0; i < 6; i++) begin
            cyc(1, 0, 100 + i, 2, 0, 1);
            cyc(1, 1, 200 + i, 2, 0, 1);
        end
        for (int i = 0; i < 20; i++) cyc(1, 0, i, 7, 0, 1);

        cyc(1, 1, 300, 1, 0, 0);
        for (int i = 0; i < 3; i++) cyc(1, 1, 301, 1, 0, 0);
        cyc(1, 1, 301, 1, 0, 1);
        cyc(1, 1, 302, 2, 0, 1);

        for (int i = 0; i < 10; i++) cyc(1, 0, 400 + i, 1, 0, 1);
        cyc(1, 0, 999, 3, 1, 1);
        for (int i = 0; i < 5; i++) cyc(1, 0, 500 + i, 3, 0, 1);

        for (int n = 0; n < 400; n++) begin
            cyc($urandom_range(0, 3) != 0,
                int'($urandom_range(0, NC - 1)),
                int'($urandom_range(0, 65535)),
                int'($urandom_range(0, MD - 1)),
                $urandom_range(0, 19) == 0,
                $urandom_range(0, 3) != 0);
        end

        #2;
        pi_arst_n = 1'b0;
        #1;
        model_reset();
        chk("arst_valid", 32'(po_valid), 32'd0);
        chk("arst_data", 32'(po_data), 32'd0);
        @(negedge pi_clk);
        pi_arst_n = 1'b1;
        for (int i = 0; i < 12; i++) cyc(1, i % 2, 600 + i, 1, 0, 1);
        cyc(0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
